// File: rtl/clock_divider_prog.sv
// clock_divider_prog: runtime-programmable 50%-duty clock divider.
// clk_out = clk_in / (2*(div_cur+1)). A new ratio is requested with div_load
// and is applied only when clk_out falls (or while parked), so clk_out never
// glitches. rise/fall are one-cycle strobes that mark the clk_out edges.
// Optional build macro CLKDIV_LOCK_EN adds a 'locked' output. It is set once
// two complete periods have run at the current ratio.

module clock_divider_prog #(
   parameter int CNT_W   = 8,
   parameter int DIV_RST = 3
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] div_in,
   input  logic             div_load,
   output logic             div_busy,
   output logic [CNT_W-1:0] div_cur,
   output logic             clk_out,
   output logic             rise,
   output logic             fall
`ifdef CLKDIV_LOCK_EN
   ,
   output logic             locked
`endif
);

   localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);

   // LOW and HIGH are the two running phases. PARK holds clk_out low while
   // en is deasserted.
   typedef enum logic [1:0] {
      ST_LOW  = 2'd0,
      ST_HIGH = 2'd1,
      ST_PARK = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [CNT_W-1:0] pending;
   logic             rise_nx, fall_nx;
   logic             phase_done;
   logic             apply;
   logic             park_entry;

   // A phase ends when the half-period counter reaches the active ratio.
   assign phase_done = (cnt == div_cur);

   // State register. Reset is synchronous, so it is sampled only at the clock edge.
   // NOTE: sequential blocks use non-blocking (<=) so that every flop samples
   // the pre-edge value of every other flop, whatever the statement order.
   always_ff @(posedge clk_in) begin
      if (rst) state <= ST_LOW;
      else     state <= state_nx;
   end

   // Next-state logic, counter update, edge strobes and the apply decision.
   // NOTE: every output of this block is given a default first, so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      rise_nx    = 1'b0;
      fall_nx    = 1'b0;
      apply      = 1'b0;
      park_entry = 1'b0;
      case (state)
         ST_LOW: begin
            if (!phase_done) begin
               cnt_nx = cnt + 1'b1;
            end else if (en) begin
               state_nx = ST_HIGH;
               cnt_nx   = '0;
               rise_nx  = 1'b1;
            end else begin
               // The counter holds at div_cur while parked. It restarts from 0 on exit.
               state_nx   = ST_PARK;
               park_entry = 1'b1;
            end
         end
         ST_HIGH: begin
            // en is ignored here, so a high phase always runs to completion.
            if (!phase_done) begin
               cnt_nx = cnt + 1'b1;
            end else begin
               state_nx = ST_LOW;
               cnt_nx   = '0;
               fall_nx  = 1'b1;
               // The new ratio governs the low phase that starts at this edge.
               apply    = div_busy;
            end
         end
         ST_PARK: begin
            // clk_out is steadily low, so a ratio can be applied on any cycle.
            apply = div_busy;
            if (en) begin
               state_nx = ST_HIGH;
               cnt_nx   = '0;
               rise_nx  = 1'b1;
            end
         end
         default: begin
            state_nx = ST_LOW;
            cnt_nx   = '0;
         end
      endcase
   end

   // Counter and registered outputs. clk_out is taken from the next state, so
   // it is a clean flop output that is aligned with the rise and fall strobes.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         cnt     <= cnt_nx;
         clk_out <= (state_nx == ST_HIGH);
         rise    <= rise_nx;
         fall    <= fall_nx;
      end
   end

   // Ratio handshake. A load always wins the busy flag, so a load that lands
   // on an apply cycle stays pending. The apply itself uses the old pending value.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         pending  <= '0;
         div_busy <= 1'b0;
         div_cur  <= DIV_RST_V;
      end else begin
         if (apply) begin
            div_cur <= pending;
         end
         if (div_load) begin
            pending  <= div_in;
            div_busy <= 1'b1;
         end else if (apply) begin
            div_busy <= 1'b0;
         end
      end
   end

`ifdef CLKDIV_LOCK_EN
   logic fall_seen;

   // Lock tracking. Any ratio change or park restarts the count. The second
   // fall strobe after a restart means two full periods at div_cur.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         fall_seen <= 1'b0;
         locked    <= 1'b0;
      end else if (apply || park_entry) begin
         fall_seen <= 1'b0;
         locked    <= 1'b0;
      end else if (fall_nx) begin
         if (fall_seen) locked    <= 1'b1;
         else           fall_seen <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_clock_divider_prog.sv
// Testbench for clock_divider_prog: directed scenarios followed by random
// en/div_load/rst traffic. Every cycle is checked against an edge-schedule model.
// Define CLKDIV_LOCK_EN to also exercise the locked output.

module tb_clock_divider_prog;

   localparam int CNT_W   = 8;
   localparam int DIV_RST = 3;

   logic             clk_in = 1'b0;
   logic             rst;
   logic             en;
   logic [CNT_W-1:0] div_in;
   logic             div_load;
   logic             div_busy;
   logic [CNT_W-1:0] div_cur;
   logic             clk_out;
   logic             rise;
   logic             fall;
`ifdef CLKDIV_LOCK_EN
   logic             locked;
`endif

   clock_divider_prog #(.CNT_W(CNT_W), .DIV_RST(DIV_RST)) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .en       (en),
      .div_in   (div_in),
      .div_load (div_load),
      .div_busy (div_busy),
      .div_cur  (div_cur),
      .clk_out  (clk_out),
      .rise     (rise),
      .fall     (fall)
`ifdef CLKDIV_LOCK_EN
      ,
      .locked   (locked)
`endif
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model. It tracks the absolute cycle of the next clk_out edge
   // rather than a counter: each phase lasts (ratio + 1) cycles.
   bit m_level, m_parked, m_busy, m_rise, m_fall;
   int m_div, m_pend, m_t_next;
`ifdef CLKDIV_LOCK_EN
   int m_nfall;
   bit m_locked;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_step();
      bit apply;
      bit clr;
      apply  = 1'b0;
      clr    = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (rst) begin
         m_level  = 1'b0;
         m_parked = 1'b0;
         m_div    = DIV_RST;
         m_pend   = 0;
         m_busy   = 1'b0;
         m_t_next = cyc + DIV_RST + 1;
`ifdef CLKDIV_LOCK_EN
         m_nfall  = 0;
         m_locked = 1'b0;
`endif
      end else begin
         if (m_parked) begin
            apply = m_busy;
            if (apply) m_div = m_pend;
            if (en) begin
               m_parked = 1'b0;
               m_level  = 1'b1;
               m_rise   = 1'b1;
               m_t_next = cyc + m_div + 1;
            end
         end else if (cyc == m_t_next) begin
            if (m_level) begin
               m_level = 1'b0;
               m_fall  = 1'b1;
               apply   = m_busy;
               if (apply) m_div = m_pend;
               m_t_next = cyc + m_div + 1;
            end else if (en) begin
               m_level  = 1'b1;
               m_rise   = 1'b1;
               m_t_next = cyc + m_div + 1;
            end else begin
               m_parked = 1'b1;
               clr      = 1'b1;
            end
         end
         if (div_load) begin
            m_pend = int'(div_in);
            m_busy = 1'b1;
         end else if (apply) begin
            m_busy = 1'b0;
         end
`ifdef CLKDIV_LOCK_EN
         if (apply || clr) begin
            m_nfall  = 0;
            m_locked = 1'b0;
         end else if (m_fall) begin
            m_nfall++;
            if (m_nfall >= 2) m_locked = 1'b1;
         end
`endif
      end
   endtask

   task automatic compare_all();
      check("clk_out", clk_out, m_level);
      check("rise", rise, m_rise);
      check("fall", fall, m_fall);
      check("div_cur", div_cur, m_div);
      check("div_busy", div_busy, m_busy);
      check("rise_fall_exclusive", rise & fall, 1'b0);
`ifdef CLKDIV_LOCK_EN
      check("locked", locked, m_locked);
`endif
   endtask

   // One clock: step the model with the inputs that the edge sampled, then
   // compare 2 ns later, away from the edge.
   task automatic tick();
      @(posedge clk_in);
      cyc++;
      model_step();
      #2;
      compare_all();
   endtask

   // Advance until the chosen strobe is seen. The wait is bounded, and a timeout counts as a failure.
   task automatic wait_strobe(input bit want_rise, input string tag);
      int k;
      logic s;
      k = 0;
      do begin
         tick();
         k++;
         s = want_rise ? rise : fall;
      end while (s !== 1'b1 && k < 40);
      check(tag, s, 1'b1);
   endtask

   initial begin
      int k;
      rst      = 1'b1;
      en       = 1'b1;
      div_load = 1'b0;
      div_in   = '0;
      tick();
      tick();
      check("rst_div_cur", div_cur, DIV_RST);
      rst = 1'b0;

      // 1: default /8, first rise on the 4th cycle after reset release
      k = 0;
      do begin
         tick();
         k++;
      end while (rise !== 1'b1 && k < 20);
      check("t1_first_rise_cycle", k, 4);
      repeat (16) tick();
      check("t1_div_cur", div_cur, 3);

      // 2: load div 0 mid-HIGH; applies at the next fall, then /2
      wait_strobe(1'b1, "t2_rise");
      tick();
      div_in   = 8'd0;
      div_load = 1'b1;
      tick();
      div_load = 1'b0;
      check("t2_busy", div_busy, 1'b1);
      wait_strobe(1'b0, "t2_fall");
      check("t2_applied", div_cur, 0);
      check("t2_busy_clear", div_busy, 1'b0);
      repeat (8) tick();

      // 3: back to div 3, then loads of 5 and 1 in one LOW phase; 5 is never used
      div_in   = 8'd3;
      div_load = 1'b1;
      tick();
      div_load = 1'b0;
      wait_strobe(1'b0, "t3_fall_a");
      check("t3_div3", div_cur, 3);
      div_in   = 8'd5;
      div_load = 1'b1;
      tick();
      div_in   = 8'd1;
      tick();
      div_load = 1'b0;
      check("t3_still_low", clk_out, 1'b0);
      wait_strobe(1'b0, "t3_fall_b");
      check("t3_applied", div_cur, 1);
      repeat (12) tick();

      // 4: en dropped during HIGH at div 3 -> finish HIGH, a full LOW, then PARK
      div_in   = 8'd3;
      div_load = 1'b1;
      tick();
      div_load = 1'b0;
      wait_strobe(1'b0, "t4_fall");
      check("t4_div3", div_cur, 3);
      wait_strobe(1'b1, "t4_rise");
      en = 1'b0;
      repeat (13) tick();
      check("t4_parked_low", clk_out, 1'b0);
      en = 1'b1;
      tick();
      check("t4_unpark_clk", clk_out, 1'b1);
      check("t4_unpark_rise", rise, 1'b1);
      repeat (6) tick();

      // 5: reset two cycles into HIGH with a load pending
      wait_strobe(1'b1, "t5_rise");
      div_in   = 8'd9;
      div_load = 1'b1;
      tick();
      div_load = 1'b0;
      check("t5_pending", div_busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_clk_out", clk_out, 1'b0);
      check("t5_div_cur", div_cur, 3);
      check("t5_busy", div_busy, 1'b0);

`ifdef CLKDIV_LOCK_EN
      // 6: load 7 while running; locked rises with the second fall after apply
      repeat (3) tick();
      div_in   = 8'd7;
      div_load = 1'b1;
      tick();
      div_load = 1'b0;
      k = 0;
      do begin
         tick();
         k++;
      end while (div_busy === 1'b1 && k < 40);
      check("t6_applied", div_busy, 1'b0);
      check("t6_div7", div_cur, 7);
      check("t6_unlocked_at_apply", locked, 1'b0);
      k = 0;
      do begin
         tick();
         k++;
      end while (locked !== 1'b1 && k < 80);
      check("t6_lock_delay", k, 32);
      check("t6_lock_with_fall", fall, 1'b1);
`endif

      // Random traffic against the model
      repeat (500) begin
         en       = ($urandom_range(0, 7) != 0);
         div_load = ($urandom_range(0, 5) == 0);
         div_in   = CNT_W'($urandom_range(0, 6));
         rst      = ($urandom_range(0, 149) == 0);
         tick();
      end
      rst      = 1'b0;
      div_load = 1'b0;
      en       = 1'b1;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
